// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the ALU command controller: FSM state encoding,
//   command framing constants and flag-byte bit positions, plus a helper
//   that assembles the flag byte from the individual ALU flags.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_AH,
        ST_GET_AL,
        ST_GET_BH,
        ST_GET_BL,
        ST_EXEC,
        ST_CAPT,
        ST_TX_HI,
        ST_TX_LO,
        ST_TX_FL
    } state_t;

    localparam logic [3:0] CMD_TAG = 4'hA;
    localparam logic [3:0] FUN_NOP = 4'hF;
    localparam logic [3:0] FUN_DIV = 4'h3;

    // Flag byte layout: {div0, 2'b0, carry, arith, logic, cmp, shift}
    localparam int unsigned FLAG_DIV0  = 7;
    localparam int unsigned FLAG_CARRY = 4;
    localparam int unsigned FLAG_ARITH = 3;
    localparam int unsigned FLAG_LOGIC = 2;
    localparam int unsigned FLAG_CMP   = 1;
    localparam int unsigned FLAG_SHIFT = 0;

    function automatic logic [7:0] pack_flags(
        input logic div0,
        input logic carry,
        input logic arith,
        input logic logc,
        input logic cmp,
        input logic shift
    );
        logic [7:0] f;
        f             = '0;
        f[FLAG_DIV0]  = div0;
        f[FLAG_CARRY] = carry;
        f[FLAG_ARITH] = arith;
        f[FLAG_LOGIC] = logc;
        f[FLAG_CMP]   = cmp;
        f[FLAG_SHIFT] = shift;
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
//   Byte-stream command controller for a 16-bit ALU. Receives a 5-byte frame
//   (CMD, A_HI, A_LO, B_HI, B_LO), holds operands and function on the ALU
//   inputs, captures the registered result and combinational flags, and
//   returns {result_hi, result_lo, flags} over a valid/ready byte interface.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data, rx_valid     incoming byte + one-cycle strobe
//   tx_data, tx_valid     response byte + valid (held until accepted)
//   tx_ready              consumer accept
//   alu_a, alu_b, alu_fun registered ALU operands / function
//   alu_out               ALU registered result
//   alu_carry..alu_shift  ALU combinational flags
//   busy                  high whenever the FSM is not idle
//   err                   one-cycle pulse for each rejected byte
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_fun,
    input  logic [15:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_arith,
    input  logic        alu_logic,
    input  logic        alu_cmp,
    input  logic        alu_shift,
    output logic        busy,
    output logic        err
);

    state_t      state,    state_nx;
    logic [3:0]  fun_q,    fun_nx;
    logic        div0_q,   div0_nx;
    logic [15:0] result_q, result_nx;
    logic [7:0]  flags_q,  flags_nx;

    logic [7:0]  tx_data_nx;
    logic        tx_valid_nx;
    logic [15:0] alu_a_nx;
    logic [15:0] alu_b_nx;
    logic [3:0]  alu_fun_nx;
    logic        busy_nx;
    logic        err_nx;
    logic        tx_accept;

    assign tx_accept = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fun_q    <= FUN_NOP;
            div0_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_fun  <= FUN_NOP;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            fun_q    <= fun_nx;
            div0_q   <= div0_nx;
            result_q <= result_nx;
            flags_q  <= flags_nx;
            tx_data  <= tx_data_nx;
            tx_valid <= tx_valid_nx;
            alu_a    <= alu_a_nx;
            alu_b    <= alu_b_nx;
            alu_fun  <= alu_fun_nx;
            busy     <= busy_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fun_nx      = fun_q;
        div0_nx     = div0_q;
        result_nx   = result_q;
        flags_nx    = flags_q;
        tx_data_nx  = tx_data;
        tx_valid_nx = tx_valid;
        alu_a_nx    = alu_a;
        alu_b_nx    = alu_b;
        alu_fun_nx  = alu_fun;
        err_nx      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data[7:4] == CMD_TAG && rx_data[3:0] != FUN_NOP) begin
                        fun_nx   = rx_data[3:0];
                        state_nx = ST_GET_AH;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_GET_AH: begin
                if (rx_valid) begin
                    alu_a_nx[15:8] = rx_data;
                    state_nx       = ST_GET_AL;
                end
            end
            ST_GET_AL: begin
                if (rx_valid) begin
                    alu_a_nx[7:0] = rx_data;
                    state_nx      = ST_GET_BH;
                end
            end
            ST_GET_BH: begin
                if (rx_valid) begin
                    alu_b_nx[15:8] = rx_data;
                    state_nx       = ST_GET_BL;
                end
            end
            ST_GET_BL: begin
                if (rx_valid) begin
                    alu_b_nx[7:0] = rx_data;
                    // Divide-by-zero is decided from the full B including the
                    // byte arriving now; the ALU then sees NOP instead of DIV.
                    div0_nx    = (fun_q == FUN_DIV) && ({alu_b[15:8], rx_data} == 16'h0000);
                    alu_fun_nx = div0_nx ? FUN_NOP : fun_q;
                    state_nx   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (rx_valid) err_nx = 1'b1;
                flags_nx = pack_flags(div0_q, alu_carry, alu_arith,
                                      alu_logic, alu_cmp, alu_shift);
                state_nx = ST_CAPT;
            end
            ST_CAPT: begin
                if (rx_valid) err_nx = 1'b1;
                // The first response byte is loaded from the value being
                // captured so tx_valid can rise on this same edge.
                result_nx   = div0_q ? 16'hFFFF : alu_out;
                alu_fun_nx  = FUN_NOP;
                tx_data_nx  = result_nx[15:8];
                tx_valid_nx = 1'b1;
                state_nx    = ST_TX_HI;
            end
            ST_TX_HI: begin
                if (rx_valid) err_nx = 1'b1;
                if (tx_accept) begin
                    tx_data_nx = result_q[7:0];
                    state_nx   = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                if (rx_valid) err_nx = 1'b1;
                if (tx_accept) begin
                    tx_data_nx = flags_q;
                    state_nx   = ST_TX_FL;
                end
            end
            ST_TX_FL: begin
                if (rx_valid) err_nx = 1'b1;
                if (tx_accept) begin
                    tx_valid_nx = 1'b0;
                    state_nx    = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl
//   Directed testbench for alu_cmd_ctrl with a small behavioural ALU stub
//   (registered result, combinational flags). Expected response bytes are
//   hand-computed constants.
module tb_alu_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out = 16'h0000;
    logic        alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_cmd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .alu_arith (alu_arith),
        .alu_logic (alu_logic),
        .alu_cmp   (alu_cmp),
        .alu_shift (alu_shift),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ALU stub: 0 ADD, 1 SUB, 3 DIV, 4 AND, 8 SHL, B compare {gt,lt}; else 0.
    function automatic logic [15:0] alu_model(input logic [15:0] a, b, input logic [3:0] f);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (f)
            4'h0:    return s[15:0];
            4'h1:    return a - b;
            4'h3:    return (b != 16'h0000) ? a / b : 16'h0000;
            4'h4:    return a & b;
            4'h8:    return a << 1;
            4'hB:    return {14'b0, a > b, a < b};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) alu_out <= alu_model(alu_a, alu_b, alu_fun);

    always_comb begin
        logic [16:0] s;
        s         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = (alu_fun == 4'h0) && s[16];
        alu_arith = (alu_fun == 4'h0) || (alu_fun == 4'h1) || (alu_fun == 4'h3);
        alu_logic = (alu_fun == 4'h4);
        alu_cmp   = (alu_fun == 4'hB);
        alu_shift = (alu_fun == 4'h8);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] b);
        send_byte(cmd);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
    endtask

    // Accepts the response with tx_ready high and checks the three bytes.
    task automatic expect_resp(input string tag, input logic [7:0] hi, lo, fl, input bit chk_lat);
        logic [7:0] bytes [3];
        int got;
        int lat;
        got = 0;
        lat = -1;
        bytes[0] = 8'h00; bytes[1] = 8'h00; bytes[2] = 8'h00;
        tx_ready = 1'b1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (tx_valid) begin
                if (got == 0) lat = c;
                bytes[got] = tx_data;
                got++;
            end
            @(posedge clk); #1;
        end
        check_eq({tag, "_count"}, got, 3);
        if (chk_lat) check_eq({tag, "_latency"}, lat, 2);
        check_eq({tag, "_hi"}, bytes[0], hi);
        check_eq({tag, "_lo"}, bytes[1], lo);
        check_eq({tag, "_fl"}, bytes[2], fl);
        check_eq({tag, "_done_valid"}, tx_valid, 0);
        check_eq({tag, "_done_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_alu_a", alu_a, 16'h0000);
        check_eq("rst_alu_b", alu_b, 16'h0000);
        check_eq("rst_alu_fun", alu_fun, 4'hF);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD 5+3 = 8, arith flag only
        send_frame(8'hA0, 16'h0005, 16'h0003);
        check_eq("add_fun_exec", alu_fun, 4'h0);
        check_eq("add_busy", busy, 1);
        check_eq("add_valid_exec", tx_valid, 0);
        expect_resp("add", 8'h00, 8'h08, 8'h08, 1'b1);
        check_eq("add_fun_ret", alu_fun, 4'hF);
        check_eq("add_a_hold", alu_a, 16'h0005);
        check_eq("add_b_hold", alu_b, 16'h0003);

        // ADD with carry out: FFFF+1 = 0, carry+arith
        send_frame(8'hA0, 16'hFFFF, 16'h0001);
        expect_resp("carry", 8'h00, 8'h00, 8'h18, 1'b1);

        // Divide by zero: ALU sees NOP, result forced FFFF, div0 flag only
        send_frame(8'hA3, 16'h0010, 16'h0000);
        check_eq("div0_fun_exec", alu_fun, 4'hF);
        expect_resp("div0", 8'hFF, 8'hFF, 8'h80, 1'b1);

        // Illegal CMD in IDLE
        send_byte(8'h55);
        check_eq("ill_err", err, 1);
        check_eq("ill_busy", busy, 0);
        check_eq("ill_valid", tx_valid, 0);
        @(posedge clk); #1;
        check_eq("ill_err_pulse", err, 0);
        // fun F is also illegal even with the right tag
        send_byte(8'hAF);
        check_eq("nop_cmd_err", err, 1);
        check_eq("nop_cmd_busy", busy, 0);

        // Extra byte while holding TX_HI
        tx_ready = 1'b0;
        send_frame(8'hA0, 16'h0005, 16'h0003);
        repeat (2) begin @(posedge clk); #1; end
        check_eq("txhi_valid", tx_valid, 1);
        send_byte(8'h77);
        check_eq("txhi_err", err, 1);
        check_eq("txhi_data", tx_data, 8'h00);
        check_eq("txhi_valid_kept", tx_valid, 1);
        expect_resp("txhi", 8'h00, 8'h08, 8'h08, 1'b0);

        // Backpressure on GT: 9 > 2 -> {gt,lt} = 2, cmp flag
        tx_ready = 1'b0;
        send_frame(8'hAB, 16'h0009, 16'h0002);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", tx_valid, 1);
            check_eq("bp_data", tx_data, 8'h00);
            @(posedge clk); #1;
        end
        expect_resp("bp", 8'h00, 8'h02, 8'h02, 1'b0);

        // CMD arriving in the cycle the flag byte is accepted is dropped
        tx_ready = 1'b1;
        send_frame(8'hA0, 16'h0001, 16'h0001);
        repeat (2) begin @(posedge clk); #1; end
        check_eq("late_hi", tx_data, 8'h00);
        @(posedge clk); #1;
        check_eq("late_lo", tx_data, 8'h02);
        @(posedge clk); #1;
        check_eq("late_fl", tx_data, 8'h08);
        send_byte(8'hA0);
        check_eq("late_err", err, 1);
        check_eq("late_busy", busy, 0);
        check_eq("late_valid", tx_valid, 0);

        // Reset after A_LO
        send_byte(8'hA0);
        send_byte(8'h12);
        send_byte(8'h34);
        check_eq("pre_rst_a", alu_a, 16'h1234);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_a", alu_a, 16'h0000);
        check_eq("mid_rst_b", alu_b, 16'h0000);
        check_eq("mid_rst_fun", alu_fun, 4'hF);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_valid", tx_valid, 0);
        check_eq("mid_rst_data", tx_data, 8'h00);
        check_eq("mid_rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(8'hA0, 16'h0100, 16'h0200);
        expect_resp("post_rst", 8'h03, 8'h00, 8'h08, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
